// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
//   Shared constants and types for the architectural register file.
//   DATA_W   : register width in bits
//   NUM_REGS : number of architectural registers
//   SEL_W    : register-select width, log2(NUM_REGS)
//   reg_idx_t: register index type
//   x_bit()  : simulation-only unknown detector for a reduction-XOR result
// -----------------------------------------------------------------------------
package register_file_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int SEL_W    = 3;

  typedef logic [SEL_W-1:0] reg_idx_t;

  // Feed this the reduction-XOR of a bus. Any X/Z bit on the bus turns the
  // XOR into X, which matches neither 0 nor 1 under case-equality. In
  // hardware the value is always 0 or 1, so this folds to a constant 0.
  function automatic logic x_bit(input logic p);
    return (p !== 1'b0) && (p !== 1'b1);
  endfunction

endpackage

// File: rtl/register_file_reg16.sv
// -----------------------------------------------------------------------------
// reg16
//   One data register with write enable and synchronous active-low clear.
//   Ports:
//     clk : clock, rising edge
//     rst : synchronous clear, active-low; has priority over en
//     en  : write enable
//     d   : data in
//     q   : registered data out
// -----------------------------------------------------------------------------
module reg16
  import register_file_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples pre-edge values, independent of process ordering.
  // NOTE: each entry is a real flop with a clear, not a RAM macro. Reads must
  // return zero after reset, so every entry needs a reset path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   Architectural register storage: eight 16-bit registers, two combinational
//   read ports and one clocked write port. No write-to-read forwarding. A
//   write becomes visible only after the edge that performs it.
//   Ports:
//     clk         : clock, rising edge
//     rst         : synchronous reset, active-low; clears all registers and
//                   overrides a write requested in the same cycle
//     read1regsel : read port 1 index
//     read2regsel : read port 2 index
//     writeregsel : write port index (don't-care when write=0)
//     writedata   : write data (don't-care when write=0)
//     write       : write enable
//     read1data   : R[read1regsel]
//     read2data   : R[read2regsel]
//     err         : unknown control input flag (simulation only; 0 in hardware)
// -----------------------------------------------------------------------------
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W_P   = DATA_W,
  parameter int NUM_REGS_P = NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SEL_W-1:0]    read1regsel,
  input  logic [SEL_W-1:0]    read2regsel,
  input  logic [SEL_W-1:0]    writeregsel,
  input  logic [DATA_W_P-1:0] writedata,
  input  logic                write,
  output logic [DATA_W_P-1:0] read1data,
  output logic [DATA_W_P-1:0] read2data,
  output logic                err
);

  logic [NUM_REGS_P-1:0] we;
  logic [DATA_W_P-1:0]   q [NUM_REGS_P];

  // Write-enable decoder, gated by write.
  // NOTE: every always_comb output gets a default first, so no path through
  // the block leaves a value held. That is what keeps latches from being
  // inferred.
  always_comb begin
    we = '0;
    for (int i = 0; i < NUM_REGS_P; i++) begin
      we[i] = write && (writeregsel == reg_idx_t'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS_P; g++) begin : g_regs
    reg16 #(.W(DATA_W_P)) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (we[g]),
      .d   (writedata),
      .q   (q[g])
    );
  end

  // Two independent 8:1 read multiplexers. They read the stored state only,
  // so a same-cycle write is not visible until after the edge.
  assign read1data = q[read1regsel];
  assign read2data = q[read2regsel];

  // An unknown writeregsel matters only when a write is actually requested.
  assign err = x_bit(write)
             | x_bit(^read1regsel)
             | x_bit(^read2regsel)
             | (write & x_bit(^writeregsel));

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Table-driven bench for register_file. Each row is driven on the falling
//   edge. Its expected read values, which reflect state before the next rising
//   edge, go into a scoreboard queue and are popped and compared shortly
//   after. Hand-written sequences cover unknown-input err behaviour.
// -----------------------------------------------------------------------------
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  read1regsel, read2regsel, writeregsel;
  logic [15:0] writedata;
  logic        write;
  logic [15:0] read1data, read2data;
  logic        err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        write;
    logic [2:0]  wsel;
    logic [15:0] wdata;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic        exp_err;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic        exp_err;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  register_file dut (
    .clk         (clk),
    .rst         (rst),
    .read1regsel (read1regsel),
    .read2regsel (read2regsel),
    .writeregsel (writeregsel),
    .writedata   (writedata),
    .write       (write),
    .read1data   (read1data),
    .read2data   (read2data),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic [2:0] ws, input logic [15:0] wd,
                     input logic [2:0] a, input logic [2:0] b,
                     input logic [15:0] e1, input logic [15:0] e2, input string nm);
    vec_t v;
    v.rst = r; v.write = w; v.wsel = ws; v.wdata = wd;
    v.r1 = a; v.r2 = b; v.exp1 = e1; v.exp2 = e2; v.exp_err = 1'b0; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic pop_and_compare();
    sb_t s;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: got empty queue, required an entry");
      return;
    end
    s = sb.pop_front();
    check({s.name, "_rd1"}, read1data, s.exp1);
    check({s.name, "_rd2"}, read2data, s.exp2);
    check({s.name, "_err"}, 16'(err), 16'(s.exp_err));
  endtask

  function automatic logic [15:0] mul1111(input int i);
    return 16'(16'h1111 * i);
  endfunction

  initial begin
    logic [2:0] xsel;
    logic       xw;
    sb_t        s;

    // ---------------- build the vector table ----------------
    add(1, 0, 0, 16'h0, 0, 7, 16'h0000, 16'h0000, "reset_state");
    for (int i = 0; i < 8; i++)
      add(1, 1, 3'(i), 16'hFFFF, 3'(i), 3'(i), 16'h0000, 16'h0000, "fill_ffff");
    add(0, 0, 0, 16'h0, 0, 7, 16'hFFFF, 16'hFFFF, "pre_reset");
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 16'h0, 3'(i), 3'(7 - i), 16'h0000, 16'h0000, "reset_clear");
    // Writes to R[i]; the read of R[7-i] sees a value only if that register
    // was written in an earlier row.
    for (int i = 0; i < 8; i++)
      add(1, 1, 3'(i), mul1111(i), 3'(i), 3'(7 - i), 16'h0000,
          (7 - i < i) ? mul1111(7 - i) : 16'h0000, "write_all");
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 16'h0, 3'(i), 3'(7 - i), mul1111(i), mul1111(7 - i), "rw_pair");
    add(1, 1, 3, 16'h0000, 3, 3, 16'h3333, 16'h3333, "r3_clear");
    add(1, 1, 3, 16'hBEEF, 3, 0, 16'h0000, 16'h0000, "no_fwd_before");
    add(1, 0, 0, 16'h0, 3, 5, 16'hBEEF, 16'h5555, "no_fwd_after");
    for (int i = 0; i < 3; i++)
      add(1, 0, 5, 16'h1234, 5, 5, 16'h5555, 16'h5555, "write_disabled");
    add(1, 0, 0, 16'h0, 5, 4, 16'h5555, 16'h4444, "r5_held");
    add(0, 1, 2, 16'hAAAA, 2, 7, 16'h2222, 16'h7777, "reset_vs_write");
    add(1, 0, 0, 16'h0, 2, 7, 16'h0000, 16'h0000, "reset_won");
    add(1, 1, 6, 16'h1357, 6, 6, 16'h0000, 16'h0000, "post_rst_write");
    add(1, 0, 0, 16'h0, 6, 2, 16'h1357, 16'h0000, "post_rst_read");

    // ---------------- initial reset ----------------
    rst = 1'b0; write = 1'b0; writeregsel = '0; writedata = '0;
    read1regsel = '0; read2regsel = '0;
    @(posedge clk);

    // ---------------- table-driven run ----------------
    foreach (vecs[k]) begin
      @(negedge clk);
      rst         = vecs[k].rst;
      write       = vecs[k].write;
      writeregsel = vecs[k].wsel;
      writedata   = vecs[k].wdata;
      read1regsel = vecs[k].r1;
      read2regsel = vecs[k].r2;
      s.exp1 = vecs[k].exp1; s.exp2 = vecs[k].exp2;
      s.exp_err = vecs[k].exp_err; s.name = vecs[k].name;
      sb.push_back(s);
      #2;
      pop_and_compare();
    end

    // ---------------- err corner cases ----------------
    // The expected err value comes from the bench's own view of the driven
    // value. A two-state simulator cannot hold X, so there both sides are 0.
    @(negedge clk);
    rst = 1'b1; write = 1'b0; read1regsel = 3'd6;
    xsel = 3'bx1x;
    read2regsel = xsel;
    #2;
    check("err_read2_x", 16'(err), 16'($isunknown(xsel)));
    read2regsel = 3'd2;
    #1;
    check("err_restored", 16'(err), 16'h0);
    check("rd1_after_err", read1data, 16'h1357);
    writeregsel = xsel;
    #1;
    check("err_wsel_x_nowrite", 16'(err), 16'h0);
    write = 1'b1;
    #1;
    check("err_wsel_x_write", 16'(err), 16'($isunknown(xsel)));
    xw = 1'bx;
    write = xw;
    writeregsel = 3'd1;
    #1;
    check("err_write_x", 16'(err), 16'($isunknown(xw)));
    write = 1'b0;
    #1;
    check("err_clean", 16'(err), 16'h0);

    // An idle edge must leave R6 untouched.
    @(posedge clk);
    #1;
    check("r6_final", read1data, 16'h1357);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
